// File: rtl/dp_fifos_rst_seq_pkg.sv
// Shared types and defaults for the FIFO reset sequencer.
package dp_fifos_rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ASSERT    = 2'd1,
      ST_WAIT_DONE = 2'd2,
      ST_COMPLETE  = 2'd3
   } seq_state_e;

   localparam int DefNumFifos      = 4;
   localparam int DefRstHoldCycles = 4;
   localparam int DefTimeoutCycles = 256;

   function automatic int cnt_width(input int timeout_cycles);
      return $clog2(timeout_cycles + 1);
   endfunction

endpackage

// File: rtl/dp_fifos_rst_rr_arbiter.sv
// Round-robin pick over a request vector, starting at i_ptr.
// Latency: combinational. Backpressure: none, caller decides when to take the grant.
// Flow control: i_req is sampled every cycle; o_gnt_vld is low when no request is set.
module dp_fifos_rst_rr_arbiter #(
   parameter int NumFifos = 4,
   parameter int IdxW     = $clog2(NumFifos)
) (
   input  logic [NumFifos-1:0] i_req,
   input  logic [IdxW-1:0]     i_ptr,
   output logic [IdxW-1:0]     o_gnt_idx,
   output logic                o_gnt_vld
);

   logic [IdxW-1:0] w_idx;

   // Walk offsets from farthest to nearest so the nearest hit to i_ptr wins.
   always_comb begin
      w_idx     = '0;
      o_gnt_idx = '0;
      o_gnt_vld = 1'b0;
      for (int off = NumFifos - 1; off >= 0; off--) begin
         w_idx = IdxW'((int'(i_ptr) + off) % NumFifos);
         if (i_req[w_idx]) begin
            o_gnt_vld = 1'b1;
            o_gnt_idx = w_idx;
         end
      end
   end

endmodule

// File: rtl/dp_fifos_rst_sequencer.sv
// Round-robin reset scheduler for the FIFO reset controllers; optional SEE re-reset via DP_FIFOS_RST_SEQ_SEE_RECOVERY_EN.
// Latency: reset request one cycle after pending is set, held RstHoldCycles, then done wait bounded by TimeoutCycles.
// Backpressure: requests arriving while busy stay pending and are granted in later rounds.
module dp_fifos_rst_sequencer
   import dp_fifos_rst_seq_pkg::*;
#(
   parameter int NumFifos      = DefNumFifos,
   parameter int RstHoldCycles = DefRstHoldCycles,
   parameter int TimeoutCycles = DefTimeoutCycles,
   parameter int CntWidth      = cnt_width(TimeoutCycles)
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic [NumFifos-1:0] req_i,
   input  logic                req_all_i,
   input  logic [NumFifos-1:0] fifo_rst_done_i,
   input  logic [NumFifos-1:0] fifo_seeerr_i,
   output logic [NumFifos-1:0] fifo_rst_req_o,
   output logic [NumFifos-1:0] ack_o,
   output logic [NumFifos-1:0] timeout_o,
   input  logic                timeout_clr_i,
   output logic [NumFifos-1:0] pending_o,
   output logic                busy_o
);

   localparam int IdxW = $clog2(NumFifos);
   localparam logic [NumFifos-1:0] OneLsb = {{(NumFifos-1){1'b0}}, 1'b1};

   seq_state_e          r_state, w_state_nxt;
   logic [CntWidth-1:0] r_cnt, w_cnt_nxt;
   logic [IdxW-1:0]     r_sel, w_sel_nxt;
   logic [IdxW-1:0]     r_ptr, w_ptr_nxt;
   logic [NumFifos-1:0] r_pending;
   logic [NumFifos-1:0] r_timeout;
   logic [NumFifos-1:0] r_req_q;
   logic                r_req_all_q;

   logic [NumFifos-1:0] w_rise;
   logic [NumFifos-1:0] w_see_rise;
   logic [NumFifos-1:0] w_clr;
   logic [NumFifos-1:0] w_to_set;
   logic [NumFifos-1:0] w_rst_req;
   logic [NumFifos-1:0] w_ack;
   logic [NumFifos-1:0] w_sel_oh;
   logic [NumFifos-1:0] w_gnt_oh;
   logic [IdxW-1:0]     w_arb_idx;
   logic                w_arb_vld;

`ifdef DP_FIFOS_RST_SEQ_SEE_RECOVERY_EN
   logic [NumFifos-1:0] r_seeerr_q;

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_seeerr_q <= '0;
      end else begin
         r_seeerr_q <= fifo_seeerr_i;
      end
   end

   assign w_see_rise = fifo_seeerr_i & ~r_seeerr_q;
`else
   logic w_seeerr_unused;
   assign w_seeerr_unused = ^fifo_seeerr_i;
   assign w_see_rise      = '0;
`endif

   assign w_rise = (req_i & ~r_req_q)
                 | {NumFifos{req_all_i & ~r_req_all_q}}
                 | w_see_rise;

   assign w_sel_oh = OneLsb << r_sel;
   assign w_gnt_oh = OneLsb << w_arb_idx;

   dp_fifos_rst_rr_arbiter #(
      .NumFifos (NumFifos),
      .IdxW     (IdxW)
   ) u_arb (
      .i_req     (r_pending),
      .i_ptr     (r_ptr),
      .o_gnt_idx (w_arb_idx),
      .o_gnt_vld (w_arb_vld)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_clr       = '0;
      w_to_set    = '0;
      w_rst_req   = '0;
      w_ack       = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_arb_vld) begin
               w_sel_nxt   = w_arb_idx;
               w_clr       = w_gnt_oh;
               w_cnt_nxt   = '0;
               w_ptr_nxt   = (w_arb_idx == IdxW'(NumFifos - 1)) ? '0 : w_arb_idx + 1'b1;
               w_state_nxt = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            w_rst_req = w_sel_oh;
            if (r_cnt == CntWidth'(RstHoldCycles - 1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_WAIT_DONE;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            w_cnt_nxt = r_cnt + 1'b1;
            // Done is checked first so a done on the terminal count still acks.
            if (fifo_rst_done_i[r_sel]) begin
               w_state_nxt = ST_COMPLETE;
            end else if (r_cnt == CntWidth'(TimeoutCycles - 1)) begin
               w_to_set    = w_sel_oh;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_COMPLETE: begin
            w_ack       = w_sel_oh;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_sel       <= '0;
         r_ptr       <= '0;
         r_pending   <= '0;
         r_timeout   <= '0;
         r_req_q     <= '0;
         r_req_all_q <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_sel       <= w_sel_nxt;
         r_ptr       <= w_ptr_nxt;
         // A fresh request for the FIFO being granted re-arms its pending bit.
         r_pending   <= (r_pending & ~w_clr) | w_rise;
         r_timeout   <= (timeout_clr_i ? '0 : r_timeout) | w_to_set;
         r_req_q     <= req_i;
         r_req_all_q <= req_all_i;
      end
   end

   assign fifo_rst_req_o = w_rst_req;
   assign ack_o          = w_ack;
   assign timeout_o      = r_timeout;
   assign pending_o      = r_pending;
   assign busy_o         = (r_state != ST_IDLE);

endmodule
